// File: rtl/nmr_param_bank.sv
// nmr_param_bank: double-buffered Avalon-MM parameter register bank.
// The CPU writes shadow registers at any time. A commit copies all
// shadows into the active outputs at once. While the sequencer is busy,
// the commit is held in PENDING so a running sequence never sees a
// partially updated parameter set.
module nmr_param_bank #(
    parameter int unsigned          NCH       = 4,
    parameter int unsigned          DATA_W    = 32,
    parameter int unsigned          ADDR_W    = 4,
    parameter logic [DATA_W-1:0]    RESET_VAL = '0
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [ADDR_W-1:0]       address,
    input  logic                    chipselect,
    input  logic                    write_n,
    input  logic [DATA_W/8-1:0]     byteenable,
    input  logic [DATA_W-1:0]       writedata,
    output logic [DATA_W-1:0]       readdata,
    input  logic                    seq_busy,
    input  logic                    hw_commit,
    output logic [NCH*DATA_W-1:0]   out_port,
    output logic                    commit_pending,
    output logic                    commit_done
);

    typedef enum logic [1:0] {IDLE, PENDING, APPLY} state_t;

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  shadow_q [NCH];
    logic [DATA_W-1:0]  shadow_d [NCH];
    logic [DATA_W-1:0]  active_q [NCH];
    logic [7:0]         count_q, count_d;
    logic               done_q, done_d;

    logic               wr_en;
    logic               csr_sel;
    logic               csr_commit;
    logic               csr_cancel;
    logic               req;
    logic               apply;
    logic [DATA_W-1:0]  csr_rd;

    // Bus decode; CSR commit and cancel both live in byte lane 0.
    always_comb begin
        wr_en      = chipselect && !write_n;
        csr_sel    = (address == ADDR_W'(NCH));
        csr_commit = wr_en && csr_sel && byteenable[0] && writedata[0];
        csr_cancel = wr_en && csr_sel && byteenable[0] && writedata[1];
        req        = csr_commit || hw_commit;
        apply      = (state_q == APPLY);
    end

    // Byte-lane merge of CPU writes into the shadow registers.
    always_comb begin
        for (int unsigned i = 0; i < NCH; i++) begin
            shadow_d[i] = shadow_q[i];
            if (wr_en && (address == ADDR_W'(i))) begin
                for (int unsigned b = 0; b < DATA_W/8; b++) begin
                    if (byteenable[b]) begin
                        shadow_d[i][8*b +: 8] = writedata[8*b +: 8];
                    end
                end
            end
        end
    end

    // Commit FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Commit FSM next state; cancel beats a simultaneous request in PENDING.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = seq_busy ? PENDING : APPLY;
                end
            end
            PENDING: begin
                if (csr_cancel) begin
                    state_d = IDLE;
                end else if (!seq_busy) begin
                    state_d = APPLY;
                end
            end
            APPLY: begin
                if (req) begin
                    state_d = seq_busy ? PENDING : APPLY;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Commit counter and done pulse follow the APPLY cycle.
    always_comb begin
        count_d = apply ? count_q + 8'd1 : count_q;
        done_d  = apply;
    end

    // Shadow and active registers; active samples the pre-write shadow.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NCH; i++) begin
                shadow_q[i] <= RESET_VAL;
                active_q[i] <= RESET_VAL;
            end
            count_q <= '0;
            done_q  <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NCH; i++) begin
                shadow_q[i] <= shadow_d[i];
                if (apply) begin
                    active_q[i] <= shadow_q[i];
                end
            end
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

    // CSR readback image.
    always_comb begin
        csr_rd    = '0;
        csr_rd[0] = (state_q == PENDING);
        csr_rd[1] = seq_busy;
        csr_rd[2] = apply;
        for (int unsigned b = 0; b < 8; b++) begin
            if (8 + b < DATA_W) begin
                csr_rd[8 + b] = count_q[b];
            end
        end
    end

    // Zero-wait-state read mux; unmapped addresses return zero.
    always_comb begin
        readdata = '0;
        if (chipselect) begin
            if (csr_sel) begin
                readdata = csr_rd;
            end
            for (int unsigned i = 0; i < NCH; i++) begin
                if (address == ADDR_W'(i)) begin
                    readdata = shadow_q[i];
                end
                if (address == ADDR_W'(NCH + 1 + i)) begin
                    readdata = active_q[i];
                end
            end
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_out
        assign out_port[g*DATA_W +: DATA_W] = active_q[g];
    end

    assign commit_pending = (state_q == PENDING);
    assign commit_done    = done_q;

endmodule

// File: tb/tb_nmr_param_bank.sv
// tb_nmr_param_bank: directed checks of nmr_param_bank with NCH=4, DATA_W=32.
module tb_nmr_param_bank;

    logic         clk;
    logic         reset_n;
    logic [3:0]   address;
    logic         chipselect;
    logic         write_n;
    logic [3:0]   byteenable;
    logic [31:0]  writedata;
    logic [31:0]  readdata;
    logic         seq_busy;
    logic         hw_commit;
    logic [127:0] out_port;
    logic         commit_pending;
    logic         commit_done;

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] OUT_A = 128'h00000000_00BB00DD_00000000_00001234;
    localparam logic [127:0] OUT_B = 128'hCAFEF00D_00BB00DD_00000000_00001234;

    nmr_param_bank #(
        .NCH      (4),
        .DATA_W   (32),
        .ADDR_W   (4),
        .RESET_VAL(32'h0)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .address       (address),
        .chipselect    (chipselect),
        .write_n       (write_n),
        .byteenable    (byteenable),
        .writedata     (writedata),
        .readdata      (readdata),
        .seq_busy      (seq_busy),
        .hw_commit     (hw_commit),
        .out_port      (out_port),
        .commit_pending(commit_pending),
        .commit_done   (commit_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    // Single write: driven at negedge, takes effect at the next posedge.
    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
        @(negedge clk);
        address    = a;
        writedata  = d;
        byteenable = be;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] d);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        #1;
        d          = readdata;
        chipselect = 1'b0;
    endtask

    initial begin
        logic [31:0] d;
        reset_n    = 1'b0;
        address    = '0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        byteenable = '0;
        writedata  = '0;
        seq_busy   = 1'b0;
        hw_commit  = 1'b0;
        #12;
        check("rst_out", out_port, 128'h0);
        check("rst_pend", commit_pending, 1'b0);
        check("rst_done", commit_done, 1'b0);
        rd(4'd4, d); check("rst_csr", d, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // Byte-lane write and ignored writes
        wr(4'd2, 32'hAABBCCDD, 4'b0101);
        rd(4'd2, d); check("lane_shadow2", d, 32'h00BB00DD);
        rd(4'd7, d); check("lane_active2", d, 32'h0);
        wr(4'd9, 32'h12345678, 4'hF);
        rd(4'd9, d); check("unmapped_rd", d, 32'h0);
        wr(4'd7, 32'hFFFFFFFF, 4'hF);
        rd(4'd7, d); check("active_ro", d, 32'h0);

        // Idle commit
        wr(4'd0, 32'h00001234, 4'hF);
        wr(4'd4, 32'h1, 4'hF);
        check("idle_out_pre", out_port, 128'h0);
        check("idle_done_pre", commit_done, 1'b0);
        rd(4'd4, d); check("idle_csr_apply", d, 32'h4);
        @(posedge clk); #1;
        check("idle_out", out_port, OUT_A);
        check("idle_done", commit_done, 1'b1);
        check("idle_pend", commit_pending, 1'b0);
        rd(4'd4, d); check("idle_count", d, 32'h100);
        @(posedge clk); #1;
        check("idle_done_end", commit_done, 1'b0);

        // Deferred commit
        wr(4'd3, 32'hCAFEF00D, 4'hF);
        @(negedge clk);
        seq_busy  = 1'b1;
        hw_commit = 1'b1;
        @(posedge clk); #1;
        hw_commit = 1'b0;
        check("defer_pend", commit_pending, 1'b1);
        repeat (50) begin
            @(posedge clk); #1;
            check("defer_hold_out", out_port, OUT_A);
            check("defer_hold_pend", commit_pending, 1'b1);
        end
        @(negedge clk);
        seq_busy = 1'b0;
        @(posedge clk); #1;
        check("defer_pend_drop", commit_pending, 1'b0);
        check("defer_out_m", out_port, OUT_A);
        @(posedge clk); #1;
        check("defer_out_m1", out_port, OUT_B);
        check("defer_done", commit_done, 1'b1);
        rd(4'd4, d); check("defer_count", d, 32'h200);

        // Cancel
        wr(4'd1, 32'h00000055, 4'hF);
        @(negedge clk);
        seq_busy = 1'b1;
        wr(4'd4, 32'h1, 4'hF);
        check("cancel_pend", commit_pending, 1'b1);
        wr(4'd4, 32'h3, 4'hF);
        check("cancel_idle", commit_pending, 1'b0);
        @(negedge clk);
        seq_busy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("cancel_out", out_port, OUT_B);
        rd(4'd4, d); check("cancel_count", d, 32'h200);
        wr(4'd4, 32'h2, 4'hF);
        @(posedge clk); #1;
        rd(4'd4, d); check("cancel_idle_noop", d, 32'h200);
        wr(4'd4, 32'h1, 4'b1110);
        repeat (2) @(posedge clk);
        #1;
        rd(4'd4, d); check("commit_be0_low", d, 32'h200);

        // Shadow write on the APPLY edge
        wr(4'd4, 32'h1, 4'hF);
        rd(4'd4, d); check("race_csr_apply", d, 32'h204);
        wr(4'd1, 32'h00000077, 4'hF);
        rd(4'd6, d); check("race_active1", d, 32'h55);
        rd(4'd1, d); check("race_shadow1", d, 32'h77);
        rd(4'd4, d); check("race_count", d, 32'h300);

        // Request during APPLY gives a back-to-back APPLY
        wr(4'd4, 32'h1, 4'hF);
        @(negedge clk);
        hw_commit = 1'b1;
        @(posedge clk); #1;
        hw_commit = 1'b0;
        rd(4'd4, d); check("b2b_first", d, 32'h404);
        check("b2b_done1", commit_done, 1'b1);
        @(posedge clk); #1;
        rd(4'd4, d); check("b2b_second", d, 32'h500);
        check("b2b_done2", commit_done, 1'b1);
        rd(4'd6, d); check("b2b_active1", d, 32'h77);

        // Counter wrap: 251 more commits bring the total to 256
        @(negedge clk);
        hw_commit = 1'b1;
        repeat (251) @(posedge clk);
        #1;
        hw_commit = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rd(4'd4, d); check("wrap_count", d, 32'h0);

        // Asynchronous reset in the middle of APPLY
        @(negedge clk);
        hw_commit = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        hw_commit = 1'b0;
        check("pre_rst_done", commit_done, 1'b1);
        #1;
        reset_n = 1'b0;
        #1;
        check("arst_out", out_port, 128'h0);
        check("arst_done", commit_done, 1'b0);
        check("arst_pend", commit_pending, 1'b0);
        rd(4'd4, d); check("arst_csr", d, 32'h0);
        rd(4'd0, d); check("arst_shadow0", d, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_out", out_port, 128'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nmr_param_bank.md
# nmr_param_bank

Parametrised Avalon-MM parameter register bank for the NMR pulse-sequencer parameter path. It replaces one write-only 32-bit output register per timing parameter with NCH double-buffered channels. The CPU writes shadow registers at any time. Shadow contents move to the active outputs atomically, on a commit that is deferred while the sequencer is running, so a sequence never sees a half-updated parameter set.

## Interface
- NCH, 4: number of parameter channels (1–16)
- DATA_W, 32: channel width in bits, multiple of 8
- ADDR_W, 4: Avalon word-address width, must satisfy 2^ADDR_W ≥ 2·NCH+1
- RESET_VAL, 0: reset value of every shadow and active register
- clk  in  1  system clock
- reset_n  in  1  reset, asynchronous, active-low
- address  in  ADDR_W  word address
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- byteenable  in  DATA_W/8  write byte lanes
- writedata  in  DATA_W  write data
- readdata  out  DATA_W  read data, combinational, zero wait states
- seq_busy  in  1  sequencer running, commits held off while high
- hw_commit  in  1  single-cycle commit request from hardware
- out_port  out  NCH·DATA_W  active values, channel i at bits [i·DATA_W +: DATA_W]
- commit_pending  out  1  high in PENDING state
- commit_done  out  1  one-cycle pulse after active registers update

## Operation
- Address map:
  - 0..NCH−1: shadow[i], read/write.
  - NCH: CSR.
  - NCH+1..2·NCH: active[i−NCH−1], read-only, writes ignored.
  - All other addresses: read 0, writes ignored.
- Write condition: write occurs when chipselect && !write_n. Only lanes with byteenable=1 are updated. Other bytes are held.
- CSR write: bit0 = commit request (COMMIT), bit1 = cancel pending (CANCEL). Other bits ignored. Commit fires only on a write with byteenable[0]=1.
- CSR read:
  - bit0 = commit_pending
  - bit1 = seq_busy
  - bit2 = state==APPLY
  - bits[15:8] = commit_count
  - all other bits 0
- commit_count: 8-bit count, increments on every APPLY, wraps 255→0.
- req = CSR COMMIT write || hw_commit.
- FSM states: IDLE, PENDING, APPLY.
  - IDLE: on req, go to APPLY if !seq_busy, else PENDING.
  - PENDING: CANCEL → IDLE. Otherwise go to APPLY when !seq_busy.
  - APPLY, one cycle:
    - at the edge leaving APPLY: active[i] ← shadow[i] for all i, commit_count+1, commit_done registered high for the following cycle.
    - next state: on req, PENDING if seq_busy, else APPLY again. Otherwise IDLE.
- CANCEL in IDLE or APPLY has no effect. When CANCEL and req occur together in PENDING, CANCEL wins → IDLE.
- A shadow write in the same cycle as the APPLY edge: active captures the pre-write shadow, and shadow takes the new data.
- req while already PENDING is merged, with no extra commit.
- Reset (asynchronous, any state):
  - shadow, active = RESET_VAL
  - out_port = {NCH{RESET_VAL}}
  - state IDLE, commit_pending=0, commit_done=0, commit_count=0
  - a pending commit is discarded.

## Timing
- Read latency 0: readdata is valid in the same cycle as address and chipselect. The read ignores write_n and byteenable.
- Shadow write takes effect at edge k. Readback of that shadow shows the new value from cycle k+1.
- Commit latency, with req sampled at edge k and seq_busy low:
  - APPLY in cycle k..k+1.
  - out_port updated at edge k+1.
  - commit_done high for cycle k+1..k+2.
  - commit_pending never asserts.
- Deferred commit, with seq_busy high at edge k:
  - commit_pending is high from edge k.
  - If seq_busy is first sampled low at edge m, APPLY runs m..m+1, out_port updates at m+1, and commit_pending drops at m.
- out_port changes only at APPLY edges or reset, and never while seq_busy was sampled high at the preceding edge.

## Test plan
- Reset: assert reset_n=0 mid-APPLY with RESET_VAL=0 → all out_port, readdata, commit_count, commit_pending and commit_done are 0 immediately, and state is IDLE.
- Byte-lane write, NCH=4, DATA_W=32: write shadow[2]=0xAABBCCDD with byteenable=4'b0101 over 0 → shadow[2] reads 0x00BB00DD and active[2] reads 0 until commit.
- Idle commit: write shadow[0]=0x1234, then CSR=0x1 with seq_busy=0 → out_port[31:0]=0x1234 one edge after the CSR edge, commit_done pulses 1 cycle, and CSR[15:8]=1.
- Deferred commit: hold seq_busy=1, pulse hw_commit → commit_pending=1 and out_port unchanged for 50 cycles. Drop seq_busy → out_port updates 1 edge after seq_busy is sampled low, and commit_pending=0.
- Cancel: in PENDING, write CSR=0x3 → IDLE, and out_port unchanged after seq_busy falls. Write 0x2 in IDLE → no effect.
- Wrap and race: perform 256 commits → count reads 0. Write shadow[1] in the APPLY cycle → active[1] holds the old value. A req during APPLY with seq_busy=0 → a second APPLY the next cycle, and count+2.
